// File: rtl/ddr5_sched_pkg.sv
// Shared types and constants for the DDR5 command scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr5_sched_pkg;

  // Command codes as seen by the output writer
  typedef enum logic [2:0] {
    ACT0 = 3'd0,
    ACT1 = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    WR0  = 3'd4,
    WR1  = 3'd5,
    PRE  = 3'd6
  } cmd_code_t;

  // Request opcodes from the trace front end; OP_ILLEGAL is swallowed at the input
  typedef enum logic [1:0] {
    OP_RD      = 2'd0,
    OP_WR      = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } req_op_t;

  // Physical address layout
  localparam int ADDR_W   = 34;
  localparam int ROW_LSB  = 18;
  localparam int ROW_W    = 16;
  localparam int BANK_LSB = 10;
  localparam int BANK_W   = 2;
  localparam int BG_LSB   = 7;
  localparam int BG_W     = 3;
  localparam int COLH_LSB = 12;
  localparam int COLH_W   = 6;
  localparam int COLL_LSB = 2;
  localparam int COLL_W   = 4;

  // Default timing in DRAM clock cycles
  localparam int DEF_QDEPTH = 16;
  localparam int DEF_T_RCD  = 39;
  localparam int DEF_T_RAS  = 76;
  localparam int DEF_T_RTP  = 18;
  localparam int DEF_T_WRP  = 76;
  localparam int DEF_T_RP   = 39;

  typedef struct packed {
    req_op_t           op;
    logic [ADDR_W-1:0] addr;
  } req_entry_t;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sched_req_fifo.sv
// In-order request queue holding decoded requests for the scheduler FSM.
// Latency: written entry is visible at the head one cycle after the push edge.
// Backpressure: writes while full and reads while empty are ignored; caller gates with count.
module sched_req_fifo
  import ddr5_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  req_entry_t               wr_dat_i,
  input  logic                     rd_en_i,
  output req_entry_t               rd_dat_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  req_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign do_wr = wr_en_i && (count_q != FULL_CNT);
  assign do_rd = rd_en_i && (count_q != '0);

  // Pointer and occupancy next-state; pointers wrap naturally at a power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_ptr_q];
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;

endmodule

// File: rtl/ddr5_cmd_scheduler.sv
// Closed-page DDR5 scheduler: expands each queued request into ACT0/ACT1, RD/WR pair, PRE.
// Latency: ACT0 one cycle after a push into an idle scheduler; CAS at ACT0+T_RCD.
// Backpressure: req_ready low while the queue holds QDEPTH entries.
module ddr5_cmd_scheduler
  import ddr5_sched_pkg::*;
#(
  parameter int QDEPTH = DEF_QDEPTH,
  parameter int T_RCD  = DEF_T_RCD,
  parameter int T_RAS  = DEF_T_RAS,
  parameter int T_RTP  = DEF_T_RTP,
  parameter int T_WRP  = DEF_T_WRP,
  parameter int T_RP   = DEF_T_RP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      cmd_valid,
  output logic [2:0]                cmd_code,
  output logic [BG_W-1:0]           cmd_bg,
  output logic [BANK_W-1:0]         cmd_bank,
  output logic [ROW_W-1:0]          cmd_row,
  output logic [COLH_W+COLL_W-1:0]  cmd_col,
  output logic [63:0]               cmd_cycle,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      busy
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ACT0, ST_ACT1, ST_WAIT_RCD, ST_CAS0, ST_CAS1,
    ST_WAIT_PRE, ST_PRE, ST_WAIT_RP
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        tmr_q, tmr_d;     // tRCD / tRP countdown
  logic [7:0]        gate_q, gate_d;   // cycles left before PRE is legal
  logic [ADDR_W-1:0] act_addr_q, act_addr_d;
  logic [63:0]       cycle_q, cycle_d;

  req_entry_t        head;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              push, wr_en, pop, have_req, head_is_wr;
  cmd_code_t         code_sel;
  logic [ADDR_W-1:0] src_addr;
  logic              unused_addr_bits;

  // Illegal ops are handshaken but never enter the queue
  assign push       = req_valid && req_ready;
  assign wr_en      = push && (req_op_t'(req_op) != OP_ILLEGAL);
  assign pop        = (state_q == ST_CAS1);
  assign head_is_wr = (head.op == OP_WR);
  // A request being written this edge is already head by the next cycle, so it can start ACT0 then
  assign have_req   = !fifo_empty || wr_en;

  sched_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_en),
    .wr_dat_i ('{op: req_op_t'(req_op), addr: req_addr}),
    .rd_en_i  (pop),
    .rd_dat_o (head),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign req_ready = (fifo_count != FULL_CNT);
  assign q_count   = fifo_count;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign cmd_cycle = cycle_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; tRP expiry chains straight into the next ACT0 when work is waiting
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (have_req) state_d = ST_ACT0;
      ST_ACT0:     state_d = ST_ACT1;
      ST_ACT1:     state_d = ST_WAIT_RCD;
      ST_WAIT_RCD: if (tmr_q <= 8'd1) state_d = ST_CAS0;
      ST_CAS0:     state_d = ST_CAS1;
      ST_CAS1:     state_d = ST_WAIT_PRE;
      ST_WAIT_PRE: if (gate_q <= 8'd1) state_d = ST_PRE;
      ST_PRE:      state_d = ST_WAIT_RP;
      ST_WAIT_RP:  if (tmr_q <= 8'd1) state_d = have_req ? ST_ACT0 : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; PRE addresses the row opened at ACT0 since the entry is gone by then
  always_comb begin
    cmd_valid = 1'b0;
    code_sel  = ACT0;
    src_addr  = '0;
    case (state_q)
      ST_ACT0: begin cmd_valid = 1'b1; code_sel = ACT0; src_addr = head.addr; end
      ST_ACT1: begin cmd_valid = 1'b1; code_sel = ACT1; src_addr = head.addr; end
      ST_CAS0: begin cmd_valid = 1'b1; code_sel = head_is_wr ? WR0 : RD0; src_addr = head.addr; end
      ST_CAS1: begin cmd_valid = 1'b1; code_sel = head_is_wr ? WR1 : RD1; src_addr = head.addr; end
      ST_PRE:  begin cmd_valid = 1'b1; code_sel = PRE;  src_addr = act_addr_q; end
      default: ;
    endcase
  end

  assign cmd_code = code_sel;
  assign cmd_bg   = src_addr[BG_LSB +: BG_W];
  assign cmd_bank = src_addr[BANK_LSB +: BANK_W];
  assign cmd_row  = src_addr[ROW_LSB +: ROW_W];
  assign cmd_col  = {src_addr[COLH_LSB +: COLH_W], src_addr[COLL_LSB +: COLL_W]};
  assign unused_addr_bits = ^{src_addr[6], src_addr[1:0]};

  // Timer next state: counters hold remaining cycles (minus one) so a compare against 1 exits on time
  always_comb begin
    tmr_d      = (tmr_q  != 8'd0) ? tmr_q  - 8'd1 : 8'd0;
    gate_d     = (gate_q != 8'd0) ? gate_q - 8'd1 : 8'd0;
    act_addr_d = act_addr_q;
    cycle_d    = cycle_q + 64'd1;
    case (state_q)
      ST_ACT0: begin
        tmr_d      = 8'(T_RCD - 1);
        gate_d     = 8'(T_RAS - 1);
        act_addr_d = head.addr;
      end
      ST_CAS0: gate_d = max8(gate_q, head_is_wr ? 8'(T_WRP) : 8'(T_RTP)) - 8'd1;
      ST_PRE:  tmr_d  = 8'(T_RP - 1);
      default: ;
    endcase
  end

  // Timer, latched-address and cycle-stamp registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q      <= '0;
      gate_q     <= '0;
      act_addr_q <= '0;
      cycle_q    <= '0;
    end else begin
      tmr_q      <= tmr_d;
      gate_q     <= gate_d;
      act_addr_q <= act_addr_d;
      cycle_q    <= cycle_d;
    end
  end

endmodule

// File: tb/tb_ddr5_cmd_scheduler.sv
// Bench for ddr5_cmd_scheduler: directed scenarios plus random traffic against a cycle-arithmetic model.
// Latency: n/a.
// Backpressure: requests are held until req_ready is seen high.
module tb_ddr5_cmd_scheduler;
  import ddr5_sched_pkg::*;

  localparam int QD = 16, TRCD = 39, TRAS = 76, TRTP = 18, TWRP = 76, TRP = 39;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [33:0] req_addr = '0;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [63:0] cmd_cycle;
  logic [4:0]  q_count;
  logic        busy;

  ddr5_cmd_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_cycle(cmd_cycle), .q_count(q_count), .busy(busy)
  );

  typedef struct packed {
    logic [63:0] cyc;
    logic [2:0]  code;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
  } rec_t;

  int      checks = 0;
  int      fails  = 0;
  longint  cyc = 0;
  rec_t    act_q[$];
  rec_t    exp_q[$];
  longint  m_push[$];
  longint  m_rd1[$];
  longint  m_prev_pre = -1000;
  longint  m_end = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 64'd0 : cyc + 1;
  always @(negedge clk) if (cmd_valid) act_q.push_back('{cmd_cycle, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed cycle %0d required end before 50000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(longint c, int code, logic [33:0] a);
    rec_t r;
    r.cyc  = 64'(c);
    r.code = 3'(code);
    r.bg   = a[9:7];
    r.bank = a[11:10];
    r.row  = a[33:18];
    r.col  = {a[17:12], a[5:2]};
    return r;
  endfunction

  // Occupancy seen during cycle c: legal pushes before c minus pops (RD1/WR1 cycles) before c
  function automatic int m_count(longint c);
    int n = 0;
    for (int i = 0; i < m_push.size(); i++) begin
      if (m_push[i] < c) n++;
      if (m_rd1[i] < c)  n--;
    end
    return n;
  endfunction

  task automatic m_accept(int op, logic [33:0] a, longint e);
    longint t, cas, pre;
    if (op == 3) return;
    t = e + 1;
    if (m_prev_pre + TRP > t) t = m_prev_pre + TRP;
    cas = t + TRCD;
    if (op == 1) pre = cas + TWRP;
    else         pre = (t + TRAS > cas + TRTP) ? t + TRAS : cas + TRTP;
    exp_q.push_back(mk(t, 0, a));
    exp_q.push_back(mk(t + 1, 1, a));
    exp_q.push_back(mk(cas, (op == 1) ? 4 : 2, a));
    exp_q.push_back(mk(cas + 1, (op == 1) ? 5 : 3, a));
    exp_q.push_back(mk(pre, 6, a));
    m_push.push_back(e);
    m_rd1.push_back(cas + 1);
    m_prev_pre = pre;
    m_end = pre + TRP;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    act_q.delete(); exp_q.delete(); m_push.delete(); m_rd1.delete();
    m_prev_pre = -1000;
    m_end = 0;
  endtask

  // Called at a negedge; offers one request, waits for acceptance, returns at the following negedge
  task automatic push_req(int op, logic [33:0] a);
    longint pred;
    int n = 0;
    pred = cyc;
    while (m_count(pred) >= QD) pred++;
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_addr  = a;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("accept cycle", 128'(cyc), 128'(pred));
    m_accept(op, a, pred);
    @(negedge clk);
    req_valid = 1'b0;
    chk("q_count after push", 128'(q_count), 128'(m_count(cyc)));
  endtask

  task automatic finish_phase(string tag);
    rec_t a;
    if (m_push.size() != 0 && m_end > cyc) begin
      while (cyc < m_end - 1) @(negedge clk);
      chk({tag, " busy before tRP end"}, 128'(busy), 128'(1));
      @(negedge clk);
      chk({tag, " busy at tRP end"}, 128'(busy), 128'(0));
    end
    repeat (5) @(negedge clk);
    chk({tag, " command count"}, 128'(act_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      a = (i < act_q.size()) ? act_q[i] : '0;
      chk($sformatf("%s cmd %0d", tag, i), 128'(a), 128'(exp_q[i]));
    end
  endtask

  function automatic rec_t act_at(int i);
    return (i < act_q.size()) ? act_q[i] : '0;
  endfunction

  initial begin
    logic [33:0] a0;
    logic [33:0] ar;
    a0 = 34'h0_1234_5678;

    // Reset values while reset is held
    hold_reset();
    chk("rst req_ready", 128'(req_ready), 128'(1));
    chk("rst q_count",   128'(q_count),   128'(0));
    chk("rst busy",      128'(busy),      128'(0));
    chk("rst cmd_valid", 128'(cmd_valid), 128'(0));
    chk("rst cmd_code",  128'(cmd_code),  128'(0));
    chk("rst cmd fields", 128'({cmd_bg, cmd_bank, cmd_row, cmd_col}), 128'(0));
    chk("rst cmd_cycle", 128'(cmd_cycle), 128'(0));

    // Single read
    release_reset();
    push_req(0, a0);
    finish_phase("single read");
    chk("read ACT0 cycle", 128'(act_at(0).cyc), 128'(1));
    chk("read RD0 cycle",  128'(act_at(2).cyc), 128'(40));
    chk("read PRE cycle",  128'(act_at(4).cyc), 128'(77));
    chk("read row",        128'(act_at(0).row), 128'(16'h048D));
    chk("read bg",         128'(act_at(0).bg),  128'(3'h4));
    chk("read bank",       128'(act_at(0).bank), 128'(2'h1));
    chk("read PRE row",    128'(act_at(4).row), 128'(16'h048D));

    // Single write
    hold_reset();
    release_reset();
    push_req(1, a0);
    finish_phase("single write");
    chk("write WR0 code",  128'(act_at(2).code), 128'(3'd4));
    chk("write PRE cycle", 128'(act_at(4).cyc),  128'(116));

    // Back-to-back reads
    hold_reset();
    release_reset();
    push_req(0, a0);
    push_req(2, 34'h3_8765_4321);
    finish_phase("back-to-back");
    chk("second ACT0 cycle", 128'(act_at(5).cyc), 128'(116));

    // Illegal op sandwiched between reads
    hold_reset();
    release_reset();
    push_req(0, a0);
    push_req(3, 34'h2_AAAA_5555);
    push_req(0, 34'h1_0F0F_F0F0);
    finish_phase("illegal op");

    // Queue fill: 17 requests, last one must wait for the first pop
    hold_reset();
    release_reset();
    for (int i = 0; i < 16; i++) begin
      ar = {2'($urandom_range(0, 3)), 32'($urandom)};
      push_req(int'($urandom_range(0, 2)), ar);
    end
    chk("full q_count",   128'(q_count),   128'(16));
    chk("full req_ready", 128'(req_ready), 128'(0));
    push_req(0, a0);
    chk("17th accept after first pop", 128'(m_push[16]), 128'(42));
    finish_phase("full queue");

    // Reset during WAIT_RCD
    hold_reset();
    release_reset();
    push_req(0, a0);
    while (cyc < 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid-rst cmd_valid", 128'(cmd_valid), 128'(0));
    chk("mid-rst q_count",   128'(q_count),   128'(0));
    chk("mid-rst busy",      128'(busy),      128'(0));
    chk("mid-rst cmd_cycle", 128'(cmd_cycle), 128'(0));
    release_reset();
    repeat (150) @(negedge clk);
    chk("no commands after mid-rst", 128'(act_q.size()), 128'(0));

    // Random traffic
    hold_reset();
    release_reset();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      ar = {2'($urandom_range(0, 3)), 32'($urandom)};
      push_req(int'($urandom_range(0, 3)), ar);
    end
    finish_phase("random");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ddr5_cmd_scheduler.md
# ddr5_cmd_scheduler

Single-channel DDR5 command scheduler between the trace front end and the DRAM command output writer. It buffers decoded CPU memory requests in an in-order queue and expands each request into a closed-page DDR5 command sequence: ACT (two cycles), RD/WR (two cycles), then PRE. All bank timing constraints are enforced in DRAM clock cycles. Each issued command carries a cycle stamp so the output writer can log it directly.

## Interface
- QDEPTH, 16, request queue depth (power of two)
- T_RCD, 39, ACT0 to RD0/WR0 minimum cycles
- T_RAS, 76, ACT0 to PRE minimum cycles
- T_RTP, 18, RD0 to PRE minimum cycles
- T_WRP, 76, WR0 to PRE minimum cycles (tCWL+tBURST+tWR)
- T_RP, 39, PRE to next ACT0 minimum cycles

- clk  in  1  DRAM clock; sole clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  queue not full
- req_op  in  2  0 = data read, 1 = data write, 2 = instruction fetch; 3 is illegal and dropped
- req_addr  in  34  physical address
- cmd_valid  out  1  command issued this cycle
- cmd_code  out  3  ACT0, ACT1, RD0, RD1, WR0, WR1, PRE
- cmd_bg  out  3  bank group, addr[9:7]
- cmd_bank  out  2  bank, addr[11:10]
- cmd_row  out  16  row, addr[33:18]
- cmd_col  out  10  column, {addr[17:12], addr[5:2]}
- cmd_cycle  out  64  free-running cycle count at issue
- q_count  out  $clog2(QDEPTH)+1  queue occupancy
- busy  out  1  FSM not IDLE or queue non-empty

## Operation
- Queue is a FIFO. A push occurs when req_valid && req_ready. An op of 3 is accepted and discarded, so it never occupies an entry.
- The head is popped on the RD1/WR1 cycle.
- FSM states and transitions:
  - IDLE → ACT0 when the queue is non-empty.
  - ACT0 → ACT1 unconditionally.
  - ACT1 → WAIT_RCD.
  - WAIT_RCD → CAS0 when T_RCD cycles have elapsed since ACT0.
  - CAS0 → CAS1.
  - CAS1 → WAIT_PRE.
  - WAIT_PRE → PRE when both T_RAS (from ACT0) and T_RTP or T_WRP (from CAS0) have elapsed.
  - PRE → WAIT_RP.
  - WAIT_RP → IDLE after T_RP cycles from PRE.
- Ops 0 and 2 issue RD0/RD1. Op 1 issues WR0/WR1.
- ACT, CAS and PRE commands carry the head entry's fields. PRE uses the fields latched at ACT0, because the entry has already been popped.
- cmd_valid is high only in ACT0, ACT1, CAS0, CAS1 and PRE.
- One 8-bit down-counter handles tRCD/tRP. A second counter handles the PRE gate: it is loaded at ACT0 with T_RAS, and at CAS0 it is loaded with max(remaining, T_RTP or T_WRP).
- cmd_cycle is a 64-bit counter that increments every cycle and wraps silently.

## Timing
- Reset values:
  - req_ready = 1, q_count = 0, busy = 0.
  - cmd_valid = 0, cmd_code = 0, and all cmd fields = 0.
  - cmd_cycle = 0, FSM in IDLE, both counters = 0.
- A request pushed at edge e into an empty, IDLE scheduler produces ACT0 in cycle e+1 and ACT1 in e+2.
- For an ACT0 at cycle t:
  - RD0/WR0 occurs at t+T_RCD and RD1/WR1 at t+T_RCD+1.
  - Read: PRE at t+max(T_RAS, T_RCD+T_RTP) = t+76.
  - Write: PRE at t+T_RCD+T_WRP = t+115.
  - The next ACT0 occurs no earlier than PRE+T_RP.
- Full queue: req_ready = 0 when q_count == QDEPTH. A simultaneous push and pop when full is not accepted, because req_ready is already low.
- Simultaneous push and pop when not full: q_count is unchanged.
- Reset mid-sequence: abandon the sequence immediately. No PRE is issued, the queue is emptied, and cmd_cycle restarts at 0.
- Read/write pointers wrap modulo QDEPTH.

## Structure
- Shared package ddr5_sched_pkg contains:
  - cmd_code_t enum: ACT0=0, ACT1, RD0, RD1, WR0, WR1, PRE.
  - req_op_t enum.
  - Address field bit-position constants.
  - Default timing constants.
  - req_entry_t struct {op, addr}.
- Sub-module sched_req_fifo (parameterized depth, req_entry_t payload, count output). The FSM and timing counters live in the top module.

## Test plan
- Single read at addr 34'h0_1234_5678, pushed at edge 0 → ACT0 at 1, ACT1 at 2, RD0 at 40, RD1 at 41, PRE at 77, busy falls at 116. Row = 16'h048D, bg = 3'h4, bank = 2'h1.
- Single write at the same address → WR0/WR1 at 40/41, PRE at 116.
- Two back-to-back reads → the second ACT0 occurs exactly at the first PRE cycle + 39 = 116.
- Push 17 requests while the scheduler is busy → req_ready drops after the 16th push and q_count = 16. It rises in the cycle after the first RD1 pop.
- Op 3 pushed between two reads → no commands are issued for it and q_count is never incremented for it.
- Assert rst in WAIT_RCD (cycle 20) → the next cycle shows cmd_valid = 0, q_count = 0, busy = 0, cmd_cycle = 0, and no PRE appears afterward.
